cpu_opponent_ctrl: RTL and testbench
====================================

# cpu_opponent_ctrl

CPU-driven command generator for the single-player mode: it plays the second fighter by producing the `move_left` / `move_right` / `jump` / `attack_req` command stream consumed by that fighter's movement block. It reads both fighters' positions and the movement block's `jump_active` status, and runs a frame-rate decision FSM randomised by an internal 16-bit LFSR. It sits between the game-mode mux and the P2 movement/attack blocks, replacing the P2 button decoder.

## Interface
- `POS_WIDTH`, 10: position width in pixels.
- `NEAR_DIST`, 48: distance at or below which the opponent counts as close.
- `FAR_DIST`, 160: distance above which the CPU always approaches.
- `DECIDE_FRAMES`, 8: frames between decisions in IDLE, and maximum APPROACH duration.
- `RETREAT_FRAMES`, 6: length of a retreat.
- `COOLDOWN_FRAMES`, 12: idle gap after a jump or attack.
- `JUMP_TIMEOUT`, 20: frames to wait for jump completion before giving up.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `SCEN` input 1: one-cycle frame tick, the same tick that drives the movement block.
- `ctrl_enable` input 1: CPU control active (game running, P2 is CPU).
- `self_x` input POS_WIDTH: CPU fighter x position.
- `opponent_x` input POS_WIDTH: human fighter x position.
- `self_jump_active` input 1: jump status from the CPU fighter's movement block.
- `move_left` output 1: registered command.
- `move_right` output 1: registered command.
- `jump` output 1: registered command.
- `attack_req` output 1: registered command.
- `state_dbg` output 3: current FSM state encoding.

## Operation
- **Shared quantities.**
  - `dist` = |self_x − opponent_x|, unsigned, computed at POS_WIDTH bits with no wrap (subtract smaller from larger).
  - `toward_right` = (opponent_x > self_x). If the positions are equal, "toward" is left and "away" is right.
- **LFSR.** Fibonacci, taps 16,14,13,11. Advances on every SCEN regardless of `ctrl_enable`. `r` = lfsr[1:0], sampled before the shift.
- **Frame counter.** `fcnt` is 8 bits. It is cleared on every state entry and incremented on each SCEN.
- **States:** IDLE=0, APPROACH=1, RETREAT=2, JUMP_REQ=3, JUMP_WAIT=4, ATTACK=5, COOLDOWN=6.
- **IDLE.** All commands are 0. On the SCEN where `fcnt` == DECIDE_FRAMES−1, decide:
  - dist > FAR_DIST → APPROACH.
  - dist ≤ NEAR_DIST:
    - r=0 → JUMP_REQ, direction away.
    - r=1 → RETREAT.
    - r=2 or r=3 → ATTACK.
  - otherwise (between the two thresholds): r=3 → JUMP_REQ toward; else → APPROACH.
- **APPROACH.** Drive the toward-direction command each frame. Exit to IDLE when dist ≤ NEAR_DIST or `fcnt` == DECIDE_FRAMES−1.
- **RETREAT.** Drive the away-direction command for RETREAT_FRAMES frames, then go to IDLE.
- **JUMP_REQ.**
  - Assert `jump` for exactly one frame, together with the latched direction command (`move_left` or `move_right`), or no direction if none was latched.
  - Then go to JUMP_WAIT.
- **JUMP_WAIT.** All commands are 0.
  - Wait for `self_jump_active` to go 1 then 0 → COOLDOWN.
  - If `fcnt` reaches JUMP_TIMEOUT−1 first → IDLE.
- **ATTACK.** Assert `attack_req` for exactly one frame, then go to COOLDOWN.
- **COOLDOWN.** All commands 0 for COOLDOWN_FRAMES frames, then go to IDLE.
- **Output invariants.** `move_left` and `move_right` are never both 1. `jump` and `attack_req` are never both 1.

## Timing
- **Reset values.**
  - State IDLE, `fcnt` 0, lfsr = LFSR_SEED.
  - All command outputs 0, `state_dbg` = 0.
- **Update rule.** State and outputs update only on a clk edge with SCEN=1, except for the `ctrl_enable` rule below. Outputs are registered and stay stable for the whole following frame, so the movement block sees them on its next SCEN.
- **Latency.** Decision SCEN → command visible 1 clk later.
- **`ctrl_enable`=0.** On the next clk edge, independent of SCEN: state goes to IDLE, `fcnt` clears, and all commands clear. The LFSR keeps running.
- **Input sampling.** `self_jump_active` is sampled only on SCEN. A jump shorter than one frame is not detected and ends in the timeout path.
- **Reset mid-operation.** Asserting `reset_n` mid-jump or mid-attack returns the block to its reset values immediately (asynchronous). No command pulse is stretched.

## Configuration
- **`CPU_ATTACK_EN` defined:** the ATTACK state exists and `attack_req` operates as above.
- **`CPU_ATTACK_EN` undefined:**
  - The ATTACK state is removed and `attack_req` is tied to 0.
  - In the close-range decision, r=2 or r=3 → RETREAT.

## Structure
- **Shared package `fighter_pkg`:** the state enum `cpu_state_t`, the LFSR tap constant, and the default thresholds.
- **Sub-module `lfsr16`:** enable, seed, 16-bit state out. Instantiated once.

## Test plan
The bench uses an LFSR reference model to predict `r`.
1. **Reset and first decision.** Hold `reset_n` low with SCEN toggling → all outputs 0, `state_dbg`=0. Release → the first decision occurs on the 8th SCEN.
2. **Approach.** self_x=100, opponent_x=400 → APPROACH, `move_right`=1 each frame. Then step opponent_x to 140 → exit to IDLE on the next SCEN (dist 40 ≤ 48).
3. **Jump handshake.** Jump decision → `jump`=1 for exactly one frame. Drive `self_jump_active` 1 for 16 frames, then 0 → COOLDOWN for 12 frames. Repeat with `self_jump_active` held 0 → return to IDLE after 20 frames.
4. **Close-range attack.** self_x=300, opponent_x=330, r=2:
   - With `CPU_ATTACK_EN`: `attack_req` for one frame, then 12 zero frames.
   - Without it: RETREAT with `move_left`=1 for 6 frames.
5. **Enable drop.** Deassert `ctrl_enable` mid-APPROACH with no SCEN pending → outputs 0 and `state_dbg`=0 one clk later.
6. **Equal positions.** self_x=opponent_x=200 with a retreat decision → `move_right`=1 and `move_left`=0 throughout.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared types, LFSR taps and default thresholds for the fighter game blocks.
package fighter_pkg;

    typedef enum logic [2:0] {
        CPU_IDLE      = 3'd0,
        CPU_APPROACH  = 3'd1,
        CPU_RETREAT   = 3'd2,
        CPU_JUMP_REQ  = 3'd3,
        CPU_JUMP_WAIT = 3'd4,
        CPU_ATTACK    = 3'd5,
        CPU_COOLDOWN  = 3'd6
    } cpu_state_t;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } cpu_dir_t;

    // Taps 16,14,13,11 of a right-shifting register: bits 0,2,3,5 feed bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned DEF_POS_WIDTH       = 10;
    localparam int unsigned DEF_NEAR_DIST       = 48;
    localparam int unsigned DEF_FAR_DIST        = 160;
    localparam int unsigned DEF_DECIDE_FRAMES   = 8;
    localparam int unsigned DEF_RETREAT_FRAMES  = 6;
    localparam int unsigned DEF_COOLDOWN_FRAMES = 12;
    localparam int unsigned DEF_JUMP_TIMEOUT    = 20;
    localparam logic [15:0] DEF_LFSR_SEED       = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances once per enable pulse.
module lfsr16
    import fighter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= i_seed;
        end else if (i_en) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/cpu_opponent_ctrl.sv
// CPU opponent: frame-rate decision FSM producing P2 move/jump/attack commands.
// Define CPU_ATTACK_EN to include the ATTACK state; otherwise close-range r=2/3 retreats.
module cpu_opponent_ctrl
    import fighter_pkg::*;
#(
    parameter int unsigned POS_WIDTH       = DEF_POS_WIDTH,
    parameter int unsigned NEAR_DIST       = DEF_NEAR_DIST,
    parameter int unsigned FAR_DIST        = DEF_FAR_DIST,
    parameter int unsigned DECIDE_FRAMES   = DEF_DECIDE_FRAMES,
    parameter int unsigned RETREAT_FRAMES  = DEF_RETREAT_FRAMES,
    parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int unsigned JUMP_TIMEOUT    = DEF_JUMP_TIMEOUT,
    parameter logic [15:0] LFSR_SEED       = DEF_LFSR_SEED
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 SCEN,
    input  logic                 ctrl_enable,
    input  logic [POS_WIDTH-1:0] self_x,
    input  logic [POS_WIDTH-1:0] opponent_x,
    input  logic                 self_jump_active,
    output logic                 move_left,
    output logic                 move_right,
    output logic                 jump,
    output logic                 attack_req,
    output logic [2:0]           state_dbg
);

    localparam logic [15:0]          SEED          = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [POS_WIDTH-1:0] NEAR_D        = POS_WIDTH'(NEAR_DIST);
    localparam logic [POS_WIDTH-1:0] FAR_D         = POS_WIDTH'(FAR_DIST);
    localparam logic [7:0]           DECIDE_LAST   = 8'(DECIDE_FRAMES - 1);
    localparam logic [7:0]           RETREAT_LAST  = 8'(RETREAT_FRAMES - 1);
    localparam logic [7:0]           COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0]           JUMP_LAST     = 8'(JUMP_TIMEOUT - 1);

    cpu_state_t           r_state, w_state_nxt, w_decide;
    cpu_dir_t             r_dir, w_dir_nxt, w_decide_dir, w_toward, w_away;
    logic [7:0]           r_fcnt, w_fcnt_nxt;
    logic                 r_seen, w_seen_nxt;
    logic                 r_left, r_right, r_jump;
    logic                 w_left_nxt, w_right_nxt, w_jump_nxt, w_attack_nxt;
    logic [1:0]           w_r;
    logic [13:0]          w_unused_lfsr_hi;
    logic [POS_WIDTH-1:0] w_dist;
    logic                 w_toward_right;

    lfsr16 u_lfsr (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_en    (SCEN),
        .i_seed  (SEED),
        .o_state ({w_unused_lfsr_hi, w_r})
    );

    // Equal positions count as "opponent to the left": toward=left, away=right.
    assign w_toward_right = (opponent_x > self_x);
    assign w_dist   = w_toward_right ? (opponent_x - self_x) : (self_x - opponent_x);
    assign w_toward = w_toward_right ? DIR_RIGHT : DIR_LEFT;
    assign w_away   = w_toward_right ? DIR_LEFT : DIR_RIGHT;

    always_comb begin
        w_decide     = CPU_APPROACH;
        w_decide_dir = w_toward;
        if (w_dist > FAR_D) begin
            w_decide = CPU_APPROACH;
        end else if (w_dist <= NEAR_D) begin
            w_decide_dir = w_away;
            case (w_r)
                2'd0:    w_decide = CPU_JUMP_REQ;
                2'd1:    w_decide = CPU_RETREAT;
`ifdef CPU_ATTACK_EN
                default: w_decide = CPU_ATTACK;
`else
                default: w_decide = CPU_RETREAT;
`endif
            endcase
        end else if (w_r == 2'd3) begin
            w_decide = CPU_JUMP_REQ;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_seen_nxt   = r_seen;
        w_fcnt_nxt   = r_fcnt;
        w_left_nxt   = r_left;
        w_right_nxt  = r_right;
        w_jump_nxt   = r_jump;
        w_attack_nxt = attack_req;
        if (!ctrl_enable) begin
            w_state_nxt  = CPU_IDLE;
            w_seen_nxt   = 1'b0;
            w_fcnt_nxt   = '0;
            w_left_nxt   = 1'b0;
            w_right_nxt  = 1'b0;
            w_jump_nxt   = 1'b0;
            w_attack_nxt = 1'b0;
        end else if (SCEN) begin
            unique case (r_state)
                CPU_IDLE: begin
                    if (r_fcnt == DECIDE_LAST) begin
                        w_state_nxt = w_decide;
                        w_dir_nxt   = w_decide_dir;
                    end
                end
                CPU_APPROACH: begin
                    if ((w_dist <= NEAR_D) || (r_fcnt == DECIDE_LAST)) w_state_nxt = CPU_IDLE;
                end
                CPU_RETREAT: begin
                    if (r_fcnt == RETREAT_LAST) w_state_nxt = CPU_IDLE;
                end
                CPU_JUMP_REQ: begin
                    w_state_nxt = CPU_JUMP_WAIT;
                    w_seen_nxt  = 1'b0;
                end
                CPU_JUMP_WAIT: begin
                    if (r_seen && !self_jump_active) w_state_nxt = CPU_COOLDOWN;
                    else if (r_fcnt == JUMP_LAST)    w_state_nxt = CPU_IDLE;
                    else if (self_jump_active)       w_seen_nxt  = 1'b1;
                end
`ifdef CPU_ATTACK_EN
                CPU_ATTACK: w_state_nxt = CPU_COOLDOWN;
`endif
                CPU_COOLDOWN: begin
                    if (r_fcnt == COOLDOWN_LAST) w_state_nxt = CPU_IDLE;
                end
                default: w_state_nxt = CPU_IDLE;
            endcase

            w_fcnt_nxt = (w_state_nxt == r_state) ? r_fcnt + 8'd1 : 8'd0;

            // Commands are a function of the state being entered, held for the whole frame.
            w_left_nxt   = 1'b0;
            w_right_nxt  = 1'b0;
            w_jump_nxt   = 1'b0;
            w_attack_nxt = 1'b0;
            unique case (w_state_nxt)
                CPU_APPROACH: begin
                    w_left_nxt  = !w_toward_right;
                    w_right_nxt = w_toward_right;
                end
                CPU_RETREAT, CPU_JUMP_REQ: begin
                    w_left_nxt  = (w_dir_nxt == DIR_LEFT);
                    w_right_nxt = (w_dir_nxt == DIR_RIGHT);
                    w_jump_nxt  = (w_state_nxt == CPU_JUMP_REQ);
                end
                CPU_ATTACK: w_attack_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CPU_IDLE;
            r_dir   <= DIR_NONE;
            r_fcnt  <= '0;
            r_seen  <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_jump  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_seen  <= w_seen_nxt;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_jump  <= w_jump_nxt;
        end
    end

`ifdef CPU_ATTACK_EN
    logic r_attack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_attack <= 1'b0;
        else          r_attack <= w_attack_nxt;
    end

    assign attack_req = r_attack;
`else
    logic w_unused_attack;

    assign w_unused_attack = w_attack_nxt;
    assign attack_req      = 1'b0;
`endif

    assign move_left  = r_left;
    assign move_right = r_right;
    assign jump       = r_jump;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_cpu_opponent_ctrl.sv
// Directed + randomized bench for cpu_opponent_ctrl against a frame-level behavioural model.
module tb_cpu_opponent_ctrl;

    localparam int NEAR = 48, FAR = 160, DEC = 8, RET = 6, COOL = 12, JTO = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SCEN = 1'b0;
    logic       ctrl_enable = 1'b0;
    logic       self_jump_active = 1'b0;
    logic [9:0] self_x = '0;
    logic [9:0] opponent_x = '0;
    logic       move_left, move_right, jump, attack_req;
    logic [2:0] state_dbg;

    int n_chk = 0;
    int n_err = 0;

    // Model: mode number, frames remaining in the mode, latched direction (-1 left, +1 right).
    int          m_st, m_rem, m_dir;
    bit          m_seen;
    logic [15:0] m_lfsr;
    logic [7:0]  m_exp;

    cpu_opponent_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .SCEN             (SCEN),
        .ctrl_enable      (ctrl_enable),
        .self_x           (self_x),
        .opponent_x       (opponent_x),
        .self_jump_active (self_jump_active),
        .move_left        (move_left),
        .move_right       (move_right),
        .jump             (jump),
        .attack_req       (attack_req),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vec(input int st, input bit l, input bit r, input bit j, input bit a);
        return {1'b0, 3'(st), l, r, j, a};
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return (l >> 1) | ({15'd0, b} << 15);
    endfunction

    function automatic logic [7:0] obs_vec();
        return {1'b0, state_dbg, move_left, move_right, jump, attack_req};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic m_goto(input int s);
        m_st   = s;
        m_seen = 1'b0;
        case (s)
            0, 1:    m_rem = DEC;
            2:       m_rem = RET;
            4:       m_rem = JTO;
            6:       m_rem = COOL;
            default: m_rem = 1;
        endcase
    endtask

    task automatic m_disable();
        m_goto(0);
        m_exp = 8'h00;
    endtask

    // Advance the model by one frame using the inputs present at the SCEN edge.
    task automatic m_frame();
        int sx, ox, d, r;
        bit tr, l, rt;
        sx = int'(self_x);
        ox = int'(opponent_x);
        d  = (sx > ox) ? sx - ox : ox - sx;
        tr = (ox > sx);
        r  = int'(m_lfsr[1:0]);
        m_lfsr = lfsr_adv(m_lfsr);
        if (!ctrl_enable) begin
            m_disable();
            return;
        end
        m_rem--;
        case (m_st)
            0: if (m_rem == 0) begin
                if (d > FAR) m_goto(1);
                else if (d <= NEAR) begin
                    m_dir = tr ? -1 : 1;
                    if (r == 0)      m_goto(3);
                    else if (r == 1) m_goto(2);
                    else begin
`ifdef CPU_ATTACK_EN
                        m_goto(5);
`else
                        m_goto(2);
`endif
                    end
                end else if (r == 3) begin
                    m_dir = tr ? 1 : -1;
                    m_goto(3);
                end else m_goto(1);
            end
            1: if (d <= NEAR || m_rem == 0) m_goto(0);
            2: if (m_rem == 0) m_goto(0);
            3: m_goto(4);
            4: begin
                if (m_seen && !self_jump_active) m_goto(6);
                else if (m_rem == 0)             m_goto(0);
                else if (self_jump_active)       m_seen = 1'b1;
            end
            5: m_goto(6);
            6: if (m_rem == 0) m_goto(0);
            default: m_goto(0);
        endcase
        l  = (m_st == 1 && !tr) || ((m_st == 2 || m_st == 3) && m_dir < 0);
        rt = (m_st == 1 && tr)  || ((m_st == 2 || m_st == 3) && m_dir > 0);
        m_exp = vec(m_st, l, rt, m_st == 3, m_st == 5);
    endtask

    task automatic check_model(input string tag);
        chk(tag, obs_vec(), m_exp);
        chk({tag, "_lr_excl"}, {7'd0, move_left & move_right}, 8'h00);
        chk({tag, "_ja_excl"}, {7'd0, jump & attack_req}, 8'h00);
    endtask

    task automatic tick(input int gap, input string tag);
        @(negedge clk);
        SCEN = 1'b1;
        m_frame();
        @(negedge clk);
        SCEN = 1'b0;
        repeat (gap) @(negedge clk);
        check_model(tag);
    endtask

    // Park in IDLE with enable low, burning LFSR steps until the next decision draws r=want.
    task automatic arrange(input int want);
        logic [15:0] l;
        int guard;
        guard = 0;
        @(negedge clk);
        ctrl_enable = 1'b0;
        @(negedge clk);
        m_disable();
        check_model("arrange_idle");
        forever begin
            l = m_lfsr;
            repeat (DEC - 1) l = lfsr_adv(l);
            if (int'(l[1:0]) == want || guard > 64) break;
            tick(1, "arrange_tick");
            guard++;
        end
        if (guard > 64) begin
            n_chk++;
            n_err++;
            $error("FAIL arrange: observed=no_r%0d expected=r%0d", want, want);
        end
        ctrl_enable = 1'b1;
    endtask

    task automatic to_decision(input string tag);
        repeat (DEC) tick(1, tag);
    endtask

    initial begin
        int t;
        // Reset held with frame ticks running
        reset_n = 1'b0;
        ctrl_enable = 1'b1;
        self_x = 10'd100;
        opponent_x = 10'd400;
        m_lfsr = 16'hACE1;
        m_disable();
        repeat (4) begin
            @(negedge clk); SCEN = 1'b1;
            @(negedge clk); SCEN = 1'b0;
            chk("reset_hold", obs_vec(), 8'h00);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DEC - 1) tick(2, "pre_decision");
        chk("idle_before_8th", {5'd0, state_dbg}, 8'h00);
        tick(2, "first_decision");
        chk("first_decision_dir", obs_vec(), vec(1, 0, 1, 0, 0));

        // Approach then close in
        repeat (3) tick(2, "approach");
        chk("approach_right", obs_vec(), vec(1, 0, 1, 0, 0));
        opponent_x = 10'd140;
        tick(2, "approach_exit");
        chk("approach_exit_idle", obs_vec(), 8'h00);

        // Jump toward from mid range, with completed jump
        self_x = 10'd100;
        opponent_x = 10'd200;
        arrange(3);
        to_decision("jump_dec");
        chk("jump_req", obs_vec(), vec(3, 0, 1, 1, 0));
        tick(1, "jump_wait");
        chk("jump_one_frame", obs_vec(), vec(4, 0, 0, 0, 0));
        self_jump_active = 1'b1;
        repeat (16) tick(1, "jump_airborne");
        self_jump_active = 1'b0;
        tick(1, "jump_land");
        chk("jump_cooldown", obs_vec(), vec(6, 0, 0, 0, 0));
        repeat (COOL - 1) tick(1, "cooldown");
        chk("cooldown_last", {5'd0, state_dbg}, 8'h06);
        tick(1, "cooldown_end");
        chk("cooldown_exit", {5'd0, state_dbg}, 8'h00);

        // Jump timeout with no airborne indication
        arrange(3);
        to_decision("jump2_dec");
        chk("jump2_req", {7'd0, jump}, 8'h01);
        tick(1, "jump2_wait");
        repeat (JTO - 1) tick(1, "jump2_waiting");
        chk("jump_timeout_last", {5'd0, state_dbg}, 8'h04);
        tick(1, "jump_timeout");
        chk("jump_timeout_idle", {5'd0, state_dbg}, 8'h00);

        // Close range, r=2
        self_x = 10'd300;
        opponent_x = 10'd330;
        arrange(2);
        to_decision("close_dec");
`ifdef CPU_ATTACK_EN
        chk("attack_pulse", obs_vec(), vec(5, 0, 0, 0, 1));
        tick(1, "attack_done");
        chk("attack_one_frame", obs_vec(), vec(6, 0, 0, 0, 0));
        repeat (COOL - 1) tick(1, "attack_cool");
        tick(1, "attack_cool_end");
        chk("attack_cool_exit", {5'd0, state_dbg}, 8'h00);
`else
        chk("close_retreat", obs_vec(), vec(2, 1, 0, 0, 0));
        repeat (RET - 1) begin
            tick(1, "close_retreat_run");
            chk("close_retreat_left", obs_vec(), vec(2, 1, 0, 0, 0));
        end
        tick(1, "close_retreat_end");
        chk("close_retreat_exit", obs_vec(), 8'h00);
`endif

        // Enable drop mid-approach, no SCEN
        self_x = 10'd100;
        opponent_x = 10'd400;
        arrange(0);
        to_decision("drop_dec");
        tick(1, "drop_approach");
        chk("drop_pre", obs_vec(), vec(1, 0, 1, 0, 0));
        ctrl_enable = 1'b0;
        @(negedge clk);
        m_disable();
        chk("enable_drop", obs_vec(), 8'h00);
        ctrl_enable = 1'b1;

        // Equal positions retreat goes right
        self_x = 10'd200;
        opponent_x = 10'd200;
        arrange(1);
        to_decision("equal_dec");
        chk("equal_retreat", obs_vec(), vec(2, 0, 1, 0, 0));
        repeat (RET - 1) begin
            tick(1, "equal_run");
            chk("equal_right", {6'd0, move_left, move_right}, 8'h01);
        end
        tick(1, "equal_end");
        chk("equal_exit", obs_vec(), 8'h00);

        // Randomized play
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) self_x = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) begin
                t = int'(self_x) + int'($urandom_range(0, 400)) - 200;
                if (t < 0) t = 0;
                if (t > 1023) t = 1023;
                opponent_x = 10'(t);
            end
            if ($urandom_range(0, 3) == 0) self_jump_active = ~self_jump_active;
            if ($urandom_range(0, 49) == 0) begin
                ctrl_enable = 1'b0;
                @(negedge clk);
                m_disable();
                check_model("rand_drop");
                tick(int'($urandom_range(0, 3)), "rand_off");
                ctrl_enable = 1'b1;
            end else begin
                tick(int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
